// File: rtl/bcd_decoder_seq.sv
// Sequential 3-digit BCD-to-binary converter (reverse double-dabble) with a
// Start/Busy/Done handshake, illegal-digit flagging and output saturation.
module bcd_decoder_seq #(
    parameter int BIN_WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [11:0]          BCDIn,
    output logic [BIN_WIDTH-1:0] BinaryOut,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error,
    output logic                 Overflow
);

    localparam int          ITERATIONS = 10;
    localparam logic [3:0]  LAST_ITER  = 4'(ITERATIONS - 1);
    localparam int unsigned MAX_INT    = (32'd1 << BIN_WIDTH) - 32'd1;
    localparam logic [9:0]  MAX_VAL    = MAX_INT[9:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Undo the double-dabble +3 correction on one digit after a right shift.
    function automatic logic [3:0] dabble_fix(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd8) begin
            res = nib - 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    function automatic logic digits_ok(input logic [11:0] bcd);
        return (bcd[11:8] <= 4'd9) && (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [21:0]            sreg_r;
    logic [21:0]            shifted_s;
    logic [21:0]            fixed_s;
    logic [3:0]             cnt_r;
    logic [BIN_WIDTH-1:0]   bin_r;
    logic [BIN_WIDTH-1:0]   result_s;
    logic                   busy_r;
    logic                   done_r;
    logic                   error_r;
    logic                   ovf_r;
    logic                   ovf_s;
    logic                   in_ok_s;
    logic                   last_s;

    // One reverse double-dabble step plus the saturated result it would yield.
    always_comb begin
        shifted_s = {1'b0, sreg_r[21:1]};
        fixed_s   = {dabble_fix(shifted_s[21:18]),
                     dabble_fix(shifted_s[17:14]),
                     dabble_fix(shifted_s[13:10]),
                     shifted_s[9:0]};
        ovf_s     = (fixed_s[9:0] > MAX_VAL);
        if (ovf_s) begin
            result_s = '1;
        end else begin
            result_s = fixed_s[BIN_WIDTH-1:0];
        end
        in_ok_s   = digits_ok(BCDIn);
        last_s    = (cnt_r == LAST_ITER);
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    if (in_ok_s) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_FINISH;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_FINISH: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered handshake/result outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sreg_r  <= 22'd0;
            cnt_r   <= 4'd0;
            bin_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (Start) begin
                        bin_r   <= '0;
                        ovf_r   <= 1'b0;
                        error_r <= ~in_ok_s;
                        busy_r  <= in_ok_s;
                        done_r  <= ~in_ok_s;
                        cnt_r   <= 4'd0;
                        if (in_ok_s) begin
                            sreg_r <= {BCDIn, 10'd0};
                        end else begin
                            sreg_r <= sreg_r;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    sreg_r <= fixed_s;
                    cnt_r  <= cnt_r + 4'd1;
                    if (last_s) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        bin_r  <= result_s;
                        ovf_r  <= ovf_s;
                    end else begin
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                    end
                end
                ST_FINISH: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign BinaryOut = bin_r;
    assign Busy      = busy_r;
    assign Done      = done_r;
    assign Error     = error_r;
    assign Overflow  = ovf_r;

endmodule

// File: tb/tb_bcd_decoder_seq.sv
// Randomized self-checking bench for bcd_decoder_seq: a countdown-based
// behavioural model is compared every cycle against 8- and 10-bit instances.
module tb_bcd_decoder_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] bcd = 12'd0;

    logic [7:0]  bin8;
    logic [9:0]  bin10;
    logic        busy8, done8, err8, ovf8;
    logic        busy10, done10, err10, ovf10;

    int vectors = 0;
    int miscompares = 0;

    // model state: cycles left until back in idle, captured value and results
    int   rem = 0;
    int   m_val = 0;
    int   m_bin8 = 0;
    int   m_bin10 = 0;
    logic m_ovf8 = 1'b0;
    logic m_err = 1'b0;

    int   lat, nbusy, first_i, second_i, v;
    logic prev_b;
    logic [11:0] rb;

    always #5 clk = ~clk;

    bcd_decoder_seq #(.BIN_WIDTH(8)) dut8 (
        .Clock(clk), .Reset(rst), .Start(start), .BCDIn(bcd),
        .BinaryOut(bin8), .Busy(busy8), .Done(done8), .Error(err8), .Overflow(ovf8)
    );

    bcd_decoder_seq #(.BIN_WIDTH(10)) dut10 (
        .Clock(clk), .Reset(rst), .Start(start), .BCDIn(bcd),
        .BinaryOut(bin10), .Busy(busy10), .Done(done10), .Error(err10), .Overflow(ovf10)
    );

    function automatic logic bcd_ok(input logic [11:0] b);
        return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic int bcd_val(input logic [11:0] b);
        return 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a valid request occupies 11 cycles, an invalid one 1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem     <= 0;
            m_val   <= 0;
            m_bin8  <= 0;
            m_bin10 <= 0;
            m_ovf8  <= 1'b0;
            m_err   <= 1'b0;
        end else if (rem == 0) begin
            if (start) begin
                rem     <= bcd_ok(bcd) ? 11 : 1;
                m_val   <= bcd_val(bcd);
                m_err   <= ~bcd_ok(bcd);
                m_bin8  <= 0;
                m_bin10 <= 0;
                m_ovf8  <= 1'b0;
            end
        end else begin
            rem <= rem - 1;
            if (rem == 2) begin
                m_bin8  <= (m_val > 255) ? 255 : m_val;
                m_ovf8  <= (m_val > 255);
                m_bin10 <= m_val;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy8",  32'(busy8),  32'(rem >= 2));
        chk("done8",  32'(done8),  32'(rem == 1));
        chk("err8",   32'(err8),   32'(m_err));
        chk("ovf8",   32'(ovf8),   32'(m_ovf8));
        chk("bin8",   32'(bin8),   32'(m_bin8));
        chk("busy10", 32'(busy10), 32'(rem >= 2));
        chk("done10", 32'(done10), 32'(rem == 1));
        chk("err10",  32'(err10),  32'(m_err));
        chk("ovf10",  32'(ovf10),  32'd0);
        chk("bin10",  32'(bin10),  32'(m_bin10));
    end

    task automatic go(input logic [11:0] b);
        @(posedge clk);
        #1 start = 1'b1;
        bcd = b;
        @(posedge clk);
        #1 start = 1'b0;
        bcd = 12'($urandom);
    endtask

    task automatic wait_done(output int l, output int nb);
        l  = 0;
        nb = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy8) nb++;
            if (done8) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic conv_lit(input logic [11:0] b, input int lat_exp, input int nb_exp,
                            input int e8, input int o8, input int e10, input int er);
        int l, nb;
        go(b);
        wait_done(l, nb);
        chk("lit_latency", 32'(l), 32'(lat_exp));
        chk("lit_busy_cycles", 32'(nb), 32'(nb_exp));
        chk("lit_bin8", 32'(bin8), 32'(e8));
        chk("lit_ovf8", 32'(ovf8), 32'(o8));
        chk("lit_bin10", 32'(bin10), 32'(e10));
        chk("lit_err", 32'(err8), 32'(er));
    endtask

    task automatic conv_model(input logic [11:0] b);
        int l, nb, n;
        n = bcd_val(b);
        go(b);
        wait_done(l, nb);
        chk("rnd_latency", 32'(l), bcd_ok(b) ? 32'd11 : 32'd1);
        if (bcd_ok(b)) begin
            chk("rnd_bin8", 32'(bin8), 32'((n > 255) ? 255 : n));
            chk("rnd_bin10", 32'(bin10), 32'(n));
        end else begin
            chk("rnd_err", 32'(err8), 32'd1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bin8", 32'(bin8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_err",  32'(err8), 32'd0);
        chk("rst_ovf",  32'(ovf8), 32'd0);
        rst = 1'b0;

        conv_lit(12'h000, 11, 10, 8'h00, 0, 0,   0);
        conv_lit(12'h255, 11, 10, 8'hFF, 0, 255, 0);
        conv_lit(12'h109, 11, 10, 8'h6D, 0, 109, 0);
        conv_lit(12'h256, 11, 10, 8'hFF, 1, 256, 0);
        conv_lit(12'h999, 11, 10, 8'hFF, 1, 10'h3E7, 0);
        conv_lit(12'h0A5, 1,  0,  8'h00, 0, 0,   1);
        conv_lit(12'h042, 11, 10, 8'h2A, 0, 42,  0);

        // second request during SHIFT must be dropped
        go(12'h123);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        bcd = 12'h045;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, nbusy);
        chk("ignored_latency", 32'(lat + 4), 32'd11);
        chk("ignored_bin8", 32'(bin8), 32'h7B);

        // Start held high: re-acceptance every 12 cycles
        @(posedge clk);
        #1 start = 1'b1;
        bcd = 12'h042;
        first_i  = -1;
        second_i = -1;
        prev_b   = 1'b0;
        for (int i = 0; i < 40 && second_i < 0; i++) begin
            @(negedge clk);
            if (busy8 && !prev_b) begin
                if (first_i < 0) first_i = i;
                else second_i = i;
            end
            prev_b = busy8;
        end
        chk("restart_period", 32'(second_i - first_i), 32'd12);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(posedge clk);

        // asynchronous abort mid-conversion
        go(12'h200);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_bin8", 32'(bin8), 32'd0);
        chk("arst_busy", 32'(busy8), 32'd0);
        chk("arst_done", 32'(done8), 32'd0);
        chk("arst_err",  32'(err8), 32'd0);
        chk("arst_ovf",  32'(ovf8), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        conv_lit(12'h200, 11, 10, 8'hC8, 0, 200, 0);

        for (int n = 0; n < 256; n++) conv_model(to_bcd(n));

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(3) == 0) rb = 12'($urandom);
            else rb = to_bcd(int'($urandom_range(999)));
            conv_model(rb);
        end

        // free-running random Start/BCDIn, checked only by the model
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1 start = ($urandom_range(2) == 0);
            v = int'($urandom_range(3));
            bcd = (v == 0) ? 12'($urandom) : to_bcd(int'($urandom_range(999)));
        end
        start = 1'b0;
        repeat (15) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
